// File: rtl/gppcu_instr_issue_pkg.sv
// Shared GPPCU opcode definitions used by the issue sequencer and the decoder.
package gppcu_instr_issue_pkg;

    localparam int OPC_BITS = 5;
    localparam logic [OPC_BITS-1:0] OPC_MAX_LEGAL = 5'd21;

    typedef enum logic [OPC_BITS-1:0] {
        OPC_NOP  = 5'd0,
        OPC_MOV  = 5'd1,
        OPC_ADI  = 5'd8,
        OPC_FADD = 5'd15,
        OPC_STL  = 5'd21
    } gppcu_opc_e;

    function automatic logic opc_is_legal(input logic [OPC_BITS-1:0] opc);
        return opc <= OPC_MAX_LEGAL;
    endfunction

endpackage

// File: rtl/gppcu_issue_fifo.sv
// Two-entry prefetch buffer between instruction memory and the issue slot.
module gppcu_issue_fifo #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/gppcu_instr_issue.sv
// GPPCU instruction fetch-and-issue sequencer.
// Optional macro GPPCU_ISSUE_PERF_EN adds cycle/stall performance counters.
module gppcu_instr_issue
    import gppcu_instr_issue_pkg::*;
#(
    parameter int INSTR_BITS = 32,
    parameter int ADDR_BITS  = 10
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iSTART,
    input  logic [ADDR_BITS:0]    iPROG_LEN,
    output logic                  oBUSY,
    output logic                  oDONE,
    output logic                  oILLEGAL,
`ifdef GPPCU_ISSUE_PERF_EN
    output logic [31:0]           oPERF_CYCLES,
    output logic [31:0]           oPERF_STALLS,
`endif
    output logic                  oIMEM_RE,
    output logic [ADDR_BITS-1:0]  oIMEM_ADDR,
    input  logic [INSTR_BITS-1:0] iIMEM_DATA,
    output logic                  oVALID,
    output logic [OPC_BITS-1:0]   oOPC,
    output logic [INSTR_BITS-1:0] oINSTR,
    input  logic                  iREADY
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e                state_q;
    logic [ADDR_BITS:0]    pc_q;
    logic [ADDR_BITS:0]    len_q;
    logic                  inflight_q;
    logic                  illegal_q;
    logic                  busy_q;
    logic                  done_q;

    logic [1:0]            fifo_cnt;
    logic [INSTR_BITS-1:0] head;
    logic                  valid;
    logic                  pop;
    logic                  rd_en;
    logic                  drained;
    logic [2:0]            occupancy;
    logic [ADDR_BITS:0]    pc_inc;
    logic [OPC_BITS-1:0]   head_opc;
    logic [OPC_BITS-1:0]   push_opc;

    gppcu_issue_fifo #(.WIDTH(INSTR_BITS)) u_fifo (
        .clk_i       (iCLK),
        .rst_i       (iRST),
        .push_i      (inflight_q),
        .push_data_i (iIMEM_DATA),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_cnt)
    );

    assign valid     = (fifo_cnt != 2'd0);
    assign pop       = valid && iREADY;
    // Words already buffered or in flight after this cycle's pop bound the prefetch depth.
    assign occupancy = {1'b0, fifo_cnt} - {2'b00, pop} + {2'b00, inflight_q};
    assign rd_en     = (state_q == S_RUN) && (pc_q < len_q) && (occupancy < 3'd2);
    assign pc_inc    = pc_q + {{ADDR_BITS{1'b0}}, 1'b1};
    assign drained   = !inflight_q && (fifo_cnt == {1'b0, pop});
    assign head_opc  = head[INSTR_BITS-1 -: OPC_BITS];
    assign push_opc  = iIMEM_DATA[INSTR_BITS-1 -: OPC_BITS];

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            len_q      <= '0;
            inflight_q <= 1'b0;
            illegal_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= rd_en;
            done_q     <= 1'b0;
            if (inflight_q && !opc_is_legal(push_opc)) illegal_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (iSTART) begin
                        illegal_q <= 1'b0;
                        pc_q      <= '0;
                        len_q     <= iPROG_LEN;
                        if (iPROG_LEN != '0) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (rd_en) begin
                        pc_q <= pc_inc;
                        if (pc_inc == len_q) state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef GPPCU_ISSUE_PERF_EN
    logic [31:0] perf_cyc_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge iCLK) begin
        if (iRST || ((state_q == S_IDLE) && iSTART)) begin
            perf_cyc_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy_q && !(&perf_cyc_q))               perf_cyc_q   <= perf_cyc_q + 32'd1;
            if (valid && !iREADY && !(&perf_stall_q))   perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign oPERF_CYCLES = perf_cyc_q;
    assign oPERF_STALLS = perf_stall_q;
`endif

    assign oBUSY      = busy_q;
    assign oDONE      = done_q;
    assign oILLEGAL   = illegal_q;
    assign oIMEM_RE   = rd_en;
    assign oIMEM_ADDR = rd_en ? pc_q[ADDR_BITS-1:0] : '0;
    assign oVALID     = valid;
    assign oOPC       = (valid && opc_is_legal(head_opc)) ? head_opc : '0;
    assign oINSTR     = valid ? head : '0;

endmodule

// File: tb/tb_gppcu_instr_issue.sv
// Scoreboard bench for gppcu_instr_issue with a 1-cycle-latency instruction memory model.
module tb_gppcu_instr_issue;
    import gppcu_instr_issue_pkg::*;

    logic        iCLK;
    logic        iRST;
    logic        iSTART;
    logic [10:0] iPROG_LEN;
    logic        oBUSY;
    logic        oDONE;
    logic        oILLEGAL;
`ifdef GPPCU_ISSUE_PERF_EN
    logic [31:0] oPERF_CYCLES;
    logic [31:0] oPERF_STALLS;
`endif
    logic        oIMEM_RE;
    logic [9:0]  oIMEM_ADDR;
    logic [31:0] iIMEM_DATA;
    logic        oVALID;
    logic [4:0]  oOPC;
    logic [31:0] oINSTR;
    logic        iREADY;

    logic [31:0] mem [1024];
    logic [31:0] mem_rd = '0;
    logic [36:0] exp_q [$];
    int          n_chk = 0;
    int          n_err = 0;

    gppcu_instr_issue #(.INSTR_BITS(32), .ADDR_BITS(10)) dut (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .iSTART       (iSTART),
        .iPROG_LEN    (iPROG_LEN),
        .oBUSY        (oBUSY),
        .oDONE        (oDONE),
        .oILLEGAL     (oILLEGAL),
`ifdef GPPCU_ISSUE_PERF_EN
        .oPERF_CYCLES (oPERF_CYCLES),
        .oPERF_STALLS (oPERF_STALLS),
`endif
        .oIMEM_RE     (oIMEM_RE),
        .oIMEM_ADDR   (oIMEM_ADDR),
        .iIMEM_DATA   (iIMEM_DATA),
        .oVALID       (oVALID),
        .oOPC         (oOPC),
        .oINSTR       (oINSTR),
        .iREADY       (iREADY)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) if (oIMEM_RE) mem_rd <= mem[oIMEM_ADDR];
    assign iIMEM_DATA = mem_rd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one program from cycle 0 (iSTART) and scoreboards every issued word.
    task automatic run(input int len, input int slo, input int shi, input int s2,
                       input int exp_done, input bit exp_ill);
        int          done_cyc = -1;
        int          done_pulses = 0;
        int          rd_cnt = 0;
        int          xfer = 0;
        int          first_issue = -1;
        int          first_rd = -1;
        bit          busy_seen = 0;
        logic [31:0] w;
        logic [36:0] e;
        for (int i = 0; i < len; i++) begin
            w = mem[i];
            exp_q.push_back({(w[31:27] > 5'd21) ? 5'd0 : w[31:27], w});
        end
        for (int c = 0; c < exp_done + 4; c++) begin
            iSTART    = (c == 0) || (c == s2);
            iPROG_LEN = (c == 0) ? 11'(len) : 11'd1;
            iREADY    = !(c >= slo && c <= shi);
            @(negedge iCLK);
            if (oBUSY) busy_seen = 1;
            if (c == 1) check("ill_clr_on_start", oILLEGAL, 0);
            if (oIMEM_RE) begin
                check("rd_addr", oIMEM_ADDR, rd_cnt[9:0]);
                if (first_rd < 0) first_rd = c;
                rd_cnt++;
            end
            check("outstanding_le3", (rd_cnt - xfer) <= 3, 1);
            if (!oVALID) begin
                check("opc_nop_when_idle", oOPC, 0);
            end else begin
                check("issue_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    check("opc", oOPC, e[36:32]);
                    check("instr", oINSTR, e[31:0]);
                    if (iREADY) begin
                        void'(exp_q.pop_front());
                        xfer++;
                        if (first_issue < 0) first_issue = c;
                    end
                end
            end
            if (oDONE) begin
                done_pulses++;
                done_cyc = c;
            end
            @(posedge iCLK);
            #1;
        end
        iSTART = 1'b0;
        iREADY = 1'b1;
        check("done_cycle", done_cyc, exp_done);
        check("done_pulses", done_pulses, 1);
        check("reads", rd_cnt, len);
        check("transfers", xfer, len);
        check("queue_empty", exp_q.size(), 0);
        check("busy_seen", busy_seen, len != 0);
        check("first_issue", first_issue, (len != 0) ? 3 : -1);
        check("first_read", first_rd, (len != 0) ? 1 : -1);
        check("illegal_sticky", oILLEGAL, exp_ill);
    endtask

    initial begin
        iRST      = 1'b1;
        iSTART    = 1'b0;
        iPROG_LEN = '0;
        iREADY    = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[0] = {OPC_ADI,  27'h0123456};
        mem[1] = {OPC_MOV,  27'h2abcdef};
        mem[2] = {OPC_FADD, 27'h1357913};
        mem[3] = {OPC_STL,  27'h7fffffe};

        repeat (2) @(posedge iCLK);
        #1;
        @(negedge iCLK);
        check("rst_busy", oBUSY, 0);
        check("rst_done", oDONE, 0);
        check("rst_valid", oVALID, 0);
        check("rst_opc", oOPC, 0);
        check("rst_instr", oINSTR, 0);
        check("rst_re", oIMEM_RE, 0);
        check("rst_illegal", oILLEGAL, 0);
        @(posedge iCLK);
        #1;
        iRST = 1'b0;

        run(4, -1, -1, -1, 7, 0);

        run(4, 4, 6, 5, 10, 0);
`ifdef GPPCU_ISSUE_PERF_EN
        check("perf_stalls", oPERF_STALLS, 3);
        check("perf_cycles", oPERF_CYCLES, 9);
`endif

        run(0, -1, -1, -1, 1, 0);

        mem[1] = {5'd27, 27'h2abcdef};
        run(4, -1, -1, -1, 7, 1);
        mem[1] = {OPC_MOV, 27'h2abcdef};

        // Reset in cycle 4 of a 4-word run.
        iSTART    = 1'b1;
        iPROG_LEN = 11'd4;
        @(posedge iCLK);
        #1;
        iSTART = 1'b0;
        repeat (3) begin
            @(posedge iCLK);
            #1;
        end
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        @(negedge iCLK);
        check("mid_rst_busy", oBUSY, 0);
        check("mid_rst_done", oDONE, 0);
        check("mid_rst_valid", oVALID, 0);
        check("mid_rst_opc", oOPC, 0);
        check("mid_rst_instr", oINSTR, 0);
        check("mid_rst_re", oIMEM_RE, 0);
        check("mid_rst_addr", oIMEM_ADDR, 0);
        repeat (4) begin
            @(posedge iCLK);
            #1;
            @(negedge iCLK);
            check("mid_rst_no_done", oDONE, 0);
            check("mid_rst_no_valid", oVALID, 0);
            check("mid_rst_no_re", oIMEM_RE, 0);
        end
        @(posedge iCLK);
        #1;
        run(4, -1, -1, -1, 7, 0);

        for (int i = 0; i < 1024; i++) mem[i] = {5'(i % 22), 27'($urandom)};
        run(1024, -1, -1, -1, 1027, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/gppcu_instr_issue.md
# gppcu_instr_issue

Instruction fetch-and-issue sequencer for the GPPCU. On a host start command it walks a program in instruction memory from address 0, prefetches words through a 2-entry buffer, and presents one instruction per cycle (opcode plus full word) to the instruction decoder and lane array under a valid/ready handshake. It pulses done when the last instruction has been accepted.

## Interface
- INSTR_BITS, 32: instruction word width; opcode is bits [INSTR_BITS-1 -: 5]
- ADDR_BITS, 10: instruction memory address width; also the program length width
- iCLK  in  1  clock; all logic on the rising edge
- iRST  in  1  reset, synchronous, active-high
- iSTART  in  1  host start request; sampled only in IDLE
- iPROG_LEN  in  ADDR_BITS+1  number of instructions to run; latched on accepted iSTART
- oBUSY  out  1  high in RUN and DRAIN
- oDONE  out  1  one-cycle completion pulse
- oILLEGAL  out  1  sticky: an opcode > 21 was fetched; cleared on accepted iSTART
- oIMEM_RE  out  1  instruction memory read enable
- oIMEM_ADDR  out  ADDR_BITS  read address
- iIMEM_DATA  in  INSTR_BITS  read data; valid exactly 1 cycle after oIMEM_RE
- oVALID  out  1  issue slot holds an instruction
- oOPC  out  5  opcode to the decoder; 0 (NOP) when !oVALID
- oINSTR  out  INSTR_BITS  full instruction word
- iREADY  in  1  consumer accepts; transfer when oVALID && iREADY

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset: state IDLE, PC 0, buffer empty, no in-flight read; all outputs 0.
- IDLE: iSTART with iPROG_LEN != 0 -> RUN, PC 0, length latched, oILLEGAL cleared. iSTART with iPROG_LEN == 0 -> DONE (no fetch). iSTART is ignored outside IDLE.
- RUN: issue a read at PC when (buffer count - pop this cycle + in-flight) < 2; PC increments per read. When PC reaches the latched length -> DRAIN.
- DRAIN: no reads. When the buffer is empty, no read is in flight, and the last word has transferred -> DONE.
- DONE: oDONE = 1 for one cycle -> IDLE.
- Buffer: 2-entry FIFO. Read data is written the cycle it returns; the head drives oOPC/oINSTR. Push and pop in the same cycle are allowed. By construction the buffer cannot overflow. A push is never dropped.
- Illegal opcode (> 21): the word is issued with oOPC forced to 0 (NOP), oINSTR unchanged, and oILLEGAL set the cycle the word enters the buffer.
- oVALID is held and oOPC/oINSTR are stable while !iREADY.
- Reset mid-program: all state is cleared at the next edge; the in-flight read data is discarded; oDONE does not pulse.
- PC is ADDR_BITS+1 wide; a length of 2^ADDR_BITS is legal and fetches every address exactly once with no wrap.

## Timing
- iSTART accepted at edge of cycle 0 -> oIMEM_RE/addr 0 in cycle 1 -> data in cycle 2 -> oVALID in cycle 3 (start-to-first-issue latency 3).
- With iREADY held high, sustained throughput is 1 instruction/cycle. An N-instruction program has oDONE in cycle N+3.
- A stall of k cycles delays oDONE by exactly k cycles.

## Configuration
- GPPCU_ISSUE_PERF_EN defined: adds oPERF_CYCLES (32b, counts cycles in RUN or DRAIN) and oPERF_STALLS (32b, counts cycles with oVALID && !iREADY). Both clear on accepted iSTART and on iRST, saturate at all-ones, and hold after DONE.
- Not defined: these ports and counters are absent. Functional behaviour is otherwise identical.

## Structure
- Opcode encodings (NOP=0 … STL=21), the opcode field width (5), and the max-legal-opcode constant live in the shared GPPCU parameter header. This block and the decoder include the same definitions.
- State encodings are local.
- One sub-module: gppcu_issue_fifo (2-entry, INSTR_BITS wide, push/pop/count, same-cycle push+pop).

## Test plan
- Program of 4 words (ADI, MOV, FADD, STL), len 4, iREADY=1, iSTART at cycle 0 -> addresses 0..3 read in cycles 1..4; oOPC 8,1,15,21 in cycles 3..6; oDONE in cycle 7 only.
- Same program, iREADY low cycles 4–6 -> oOPC holds 1 during the stall; at most 2 reads outstanding beyond the head; oDONE in cycle 10; no word lost or duplicated.
- iPROG_LEN=0 -> no oIMEM_RE; oDONE in cycle 1; oBUSY never high.
- Word with opcode 27 at address 1 -> second issue shows oOPC=0 with the raw oINSTR; oILLEGAL=1 until the next iSTART.
- iRST asserted in cycle 4 of a 4-word run -> cycle 5: all outputs 0, state IDLE; no oDONE; a new iSTART restarts from address 0.
- With GPPCU_ISSUE_PERF_EN and the stall case -> oPERF_STALLS=3 and oPERF_CYCLES=9 after done.
